// File: rtl/fifo_word_unpacker_if.sv
// FIFO read-side and narrow beat stream of the word unpacker.
// The slave modport is the unpacker's view and the master modport is the driver's view.
interface fifo_word_unpacker_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 64,
    parameter int CNT_W  = 32
);
    localparam int LW = $clog2(LANES);

    logic [LANES*LANE_W-1:0] FIFO_Q;
    logic                    FIFO_VALID;
    logic                    RD_EN;
    logic                    FLUSH;
    logic [LANE_W-1:0]       Q;
    logic [LW-1:0]           Q_LANE;
    logic                    Q_LAST;
    logic                    Q_VALID;
    logic                    Q_READY;
    logic [CNT_W-1:0]        WORD_CNT;

    modport master (
        output FIFO_Q, FIFO_VALID, FLUSH, Q_READY,
        input  RD_EN, Q, Q_LANE, Q_LAST, Q_VALID, WORD_CNT
    );

    modport slave (
        input  FIFO_Q, FIFO_VALID, FLUSH, Q_READY,
        output RD_EN, Q, Q_LANE, Q_LAST, Q_VALID, WORD_CNT
    );
endinterface

// File: rtl/fifo_word_unpacker.sv
// Drains wide FWFT FIFO words into LANES narrow beats tagged with lane index/last, counts drained words.
// Latency: RD_EN same cycle as FIFO_VALID from idle, lane 0 one cycle later; one beat/cycle sustained.
// Backpressure: beat held stable while Q_READY is low; FIFO is popped only when the last lane leaves.
module fifo_word_unpacker #(
    parameter int LANES  = 8,
    parameter int LANE_W = 64,
    parameter int CNT_W  = 32
) (
    input logic                 CLK,
    input logic                 RST_N,
    fifo_word_unpacker_if.slave bus
);
    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [LANE_W-1:0] hold_q [LANES];
    logic [CNT_W-1:0]  cnt_q;
    logic              accept;
    logic              last_lane;
    logic              load;
    logic              cnt_inc;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            lane_q  <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < LANES; k++) hold_q[k] <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
            if (load) begin
                for (int k = 0; k < LANES; k++) hold_q[k] <= bus.FIFO_Q[k*LANE_W +: LANE_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        cnt_inc   = 1'b0;
        last_lane = (lane_q == LAST_LANE);
        accept    = (state_q == STREAM) & bus.Q_READY;
        // A new word may only enter when nothing is held or the last lane leaves this cycle.
        load      = bus.FIFO_VALID & ~bus.FLUSH &
                    ((state_q == IDLE) | (accept & last_lane));

        if (bus.FLUSH) begin
            state_d = IDLE;
            lane_d  = '0;
        end else if (load) begin
            state_d = STREAM;
            lane_d  = '0;
            cnt_inc = accept & last_lane;
        end else if (accept) begin
            if (last_lane) begin
                state_d = IDLE;
                lane_d  = '0;
                cnt_inc = 1'b1;
            end else begin
                lane_d = lane_q + LW'(1);
            end
        end
    end

    assign bus.RD_EN    = load & RST_N;
    assign bus.Q        = hold_q[lane_q];
    assign bus.Q_LANE   = lane_q;
    assign bus.Q_VALID  = (state_q == STREAM);
    assign bus.Q_LAST   = (state_q == STREAM) & last_lane;
    assign bus.WORD_CNT = cnt_q;
endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Directed bench for fifo_word_unpacker: FIFO model feeds words, expected beats are queued on every pop
// and compared against each beat the unpacker presents.
module tb_fifo_word_unpacker;
    localparam int LANES  = 8;
    localparam int LANE_W = 64;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [LANE_W-1:0] dat;
        logic [2:0]        lane;
        logic              last;
    } beat_t;

    logic CLK = 1'b0;
    logic RST_N;

    fifo_word_unpacker_if #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

    fifo_word_unpacker #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [LANES*LANE_W-1:0] fifo_mem [$];
    beat_t                   exp_q [$];
    logic                    fifo_en;
    logic                    m_hv;
    logic [CNT_W-1:0]        m_cnt;
    logic                    mon_en;
    logic                    rand_rdy;
    logic                    acc_this, rden_this, qlast_this;
    int                      n_tests = 0;
    int                      n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*LANE_W-1:0] make_word(input int w);
        logic [LANES*LANE_W-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*LANE_W +: LANE_W] = {w[31:0], k[31:0]};
        return r;
    endfunction

    task automatic drive_fifo();
        bus.FIFO_VALID = fifo_en && (fifo_mem.size() > 0);
        bus.FIFO_Q     = (fifo_mem.size() > 0) ? fifo_mem[0] : '0;
    endtask

    task automatic push_word(input int w);
        fifo_mem.push_back(make_word(w));
        drive_fifo();
    endtask

    // One clock: check presented beat and pop decision at the falling edge, then advance the model.
    task automatic cycle();
        logic                    acc, ld, was_last;
        beat_t                   b;
        logic [LANES*LANE_W-1:0] w;
        @(negedge CLK);
        acc_this = 1'b0; rden_this = 1'b0; qlast_this = 1'b0;
        if (mon_en) begin
            chk("q_valid", bus.Q_VALID, m_hv);
            chk("word_cnt", bus.WORD_CNT, m_cnt);
            was_last = 1'b0;
            if (m_hv) begin
                b = exp_q[0];
                chk("q_dat", bus.Q, b.dat);
                chk("q_lane", bus.Q_LANE, b.lane);
                chk("q_last", bus.Q_LAST, b.last);
                was_last = b.last;
            end
            acc = m_hv & bus.Q_READY;
            ld  = bus.FIFO_VALID & ~bus.FLUSH & (~m_hv | (acc & was_last));
            chk("rd_en", bus.RD_EN, ld);
            acc_this   = acc;
            rden_this  = bus.RD_EN;
            qlast_this = acc & bus.Q_LAST;
            if (acc) void'(exp_q.pop_front());
            if (bus.FLUSH) begin
                exp_q.delete();
            end else begin
                if (acc && was_last) m_cnt = m_cnt + 1'b1;
                if (ld) begin
                    w = fifo_mem.pop_front();
                    for (int k = 0; k < LANES; k++) begin
                        b.dat  = w[k*LANE_W +: LANE_W];
                        b.lane = 3'(k);
                        b.last = (k == LANES - 1);
                        exp_q.push_back(b);
                    end
                end
            end
            m_hv = (exp_q.size() != 0);
        end
        @(posedge CLK);
        #1;
        bus.FLUSH = 1'b0;
        if (rand_rdy) bus.Q_READY = 1'($urandom_range(0, 1));
        drive_fifo();
    endtask

    initial begin
        int  n_acc, n_rd, n_last, n_lastok, first, lastc;
        bit  done;

        RST_N = 1'b0; mon_en = 1'b0; rand_rdy = 1'b0;
        m_hv = 1'b0; m_cnt = '0; fifo_en = 1'b1;
        bus.Q_READY = 1'b1; bus.FLUSH = 1'b0;
        push_word(0);

        // Reset and idle: FIFO offers a word but reset blocks the pop.
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rd_en", bus.RD_EN, 1'b0);
        chk("rst_q_valid", bus.Q_VALID, 1'b0);
        chk("rst_q", bus.Q, 64'd0);
        chk("rst_q_lane", bus.Q_LANE, 3'd0);
        chk("rst_q_last", bus.Q_LAST, 1'b0);
        chk("rst_word_cnt", bus.WORD_CNT, 4'd0);
        RST_N = 1'b1;
        #1;
        chk("rel_rd_en", bus.RD_EN, 1'b1);
        mon_en = 1'b1;
        cycle();
        chk("rel_q_valid", bus.Q_VALID, 1'b1);
        chk("rel_q_lane", bus.Q_LANE, 3'd0);
        repeat (11) cycle();

        // Streaming: three preloaded words, ready held high.
        fifo_en = 1'b0;
        push_word(1); push_word(2); push_word(3);
        fifo_en = 1'b1;
        drive_fifo();
        n_acc = 0; n_rd = 0; n_last = 0; n_lastok = 0; first = -1; lastc = -1;
        for (int c = 0; c < 26; c++) begin
            cycle();
            if (acc_this) begin
                n_acc++;
                if (first < 0) first = c;
                lastc = c;
                if (qlast_this) begin
                    n_last++;
                    if (n_acc % 8 == 0) n_lastok++;
                end
            end
            if (rden_this) n_rd++;
        end
        chk("stream_beats", 64'(n_acc), 64'd24);
        chk("stream_first", 64'(first), 64'd1);
        chk("stream_span", 64'(lastc - first), 64'd23);
        chk("stream_last_cnt", 64'(n_last), 64'd3);
        chk("stream_last_pos", 64'(n_lastok), 64'd3);
        chk("stream_rd_en", 64'(n_rd), 64'd3);
        chk("stream_word_cnt", bus.WORD_CNT, 4'd4);

        // Backpressure: random ready, same three-word pattern.
        rand_rdy = 1'b1;
        push_word(1); push_word(2); push_word(3);
        n_acc = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cycle();
            if (acc_this) n_acc++;
            done = (fifo_mem.size() == 0) && !m_hv;
        end
        chk("bp_drained", done, 1'b1);
        chk("bp_beats", 64'(n_acc), 64'd24);
        rand_rdy = 1'b0;
        bus.Q_READY = 1'b1;
        cycle();
        chk("bp_word_cnt", bus.WORD_CNT, 4'd7);

        // Underflow: one word, a gap with the FIFO empty, then the next word.
        push_word(7);
        repeat (9) cycle();
        repeat (5) cycle();
        chk("gap_q_valid", bus.Q_VALID, 1'b0);
        push_word(8);
        #1;
        chk("gap_rd_en", bus.RD_EN, 1'b1);
        cycle();
        chk("gap_w2_valid", bus.Q_VALID, 1'b1);
        chk("gap_w2_lane", bus.Q_LANE, 3'd0);
        chk("gap_w2_dat", bus.Q, {32'd8, 32'd0});
        repeat (9) cycle();
        chk("gap_word_cnt", bus.WORD_CNT, 4'd9);

        // Flush mid-word: lane 3 of word 9 accepted together with FLUSH.
        push_word(9); push_word(10);
        repeat (4) cycle();
        chk("fl_lane3", bus.Q_LANE, 3'd3);
        bus.FLUSH = 1'b1;
        cycle();
        chk("fl_q_valid", bus.Q_VALID, 1'b0);
        chk("fl_word_cnt", bus.WORD_CNT, 4'd9);
        repeat (10) cycle();
        chk("fl_after_cnt", bus.WORD_CNT, 4'd10);

        // Flush on an accepted last lane while the FIFO offers the next word.
        push_word(11);
        repeat (8) cycle();
        chk("fll_last", bus.Q_LAST, 1'b1);
        push_word(12);
        bus.FLUSH = 1'b1;
        cycle();
        chk("fll_rd_en", rden_this, 1'b0);
        chk("fll_word_cnt", bus.WORD_CNT, 4'd10);
        repeat (10) cycle();
        chk("fll_after_cnt", bus.WORD_CNT, 4'd11);

        // Counter wrap: reset, then 17 words through a 4-bit counter.
        RST_N = 1'b0; mon_en = 1'b0;
        fifo_mem.delete(); exp_q.delete();
        m_hv = 1'b0; m_cnt = '0;
        for (int i = 0; i < 17; i++) push_word(100 + i);
        #1;
        chk("wrap_rst_cnt", bus.WORD_CNT, 4'd0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1; mon_en = 1'b1;
        #1;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cycle();
            done = (fifo_mem.size() == 0) && !m_hv;
        end
        chk("wrap_drained", done, 1'b1);
        cycle();
        chk("wrap_word_cnt", bus.WORD_CNT, 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
